rr_reg_arbiter: RTL



---
 rtl/rr_reg_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit capture register between NREQ requesters.
// A winner owns the register until it drops its request or its HOLD-cycle budget runs out.
module rr_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d_bus,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        owner,
  output logic                  busy,
  output logic                  q_valid
);

  localparam int CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  q_q;
  logic [IDW-1:0]    owner_q;
  logic [IDW-1:0]    ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic              busy_q;
  logic              q_valid_q;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [IDW-1:0]    cand;
  logic [WIDTH-1:0]  win_data;
  logic [WIDTH-1:0]  owner_data;
  logic              release_d;
  logic [IDW-1:0]    ptr_d;

  // Rotating search: the first set request at or after ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_data   = d_bus[win_idx*WIDTH +: WIDTH];
  assign owner_data = d_bus[owner_q*WIDTH +: WIDTH];
  assign release_d  = !req[owner_q] || (cnt_q == CNTW'(HOLD - 1));
  assign ptr_d      = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q     <= NREQ'(1) << win_idx;
            owner_q   <= win_idx;
            q_q       <= win_data;
            q_valid_q <= 1'b1;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // Releasing always passes through IDLE, so grants are never back-to-back.
          if (release_d) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            q_q   <= owner_data;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign q_valid = q_valid_q;

endmodule
